// File: rtl/uart_cfg.sv
// Configurable UART peripheral on an 8-bit Wishbone-style register port.
// TX/RX FIFOs, runtime frame format (5-8 data bits, parity, 1/2 stop), level irq.

module uart_cfg_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout_c,
  output logic       empty_c,
  output logic       full_c
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign empty_c = (count == '0);
  assign full_c  = (count == CW'(DEPTH));
  assign do_push = push & ~full_c;
  assign do_pop  = pop & ~empty_c;
  assign dout_c  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

module uart_cfg #(
  parameter int unsigned TX_DEPTH  = 16,
  parameter int unsigned RX_DEPTH  = 16,
  parameter int unsigned DIV_RESET = 6
) (
  input  logic       clk,
  input  logic       reset,
  output logic       tx,
  input  logic       rx,
  input  logic [2:0] wb_addr,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  input  logic       wb_we,
  input  logic       wb_stb,
  output logic       wb_ack,
  output logic       irq
);
  localparam int unsigned DW = 8;
  localparam logic [2:0] A_TXDATA = 3'd0;
  localparam logic [2:0] A_RXDATA = 3'd1;
  localparam logic [2:0] A_DIV    = 3'd2;
  localparam logic [2:0] A_CTRL   = 3'd3;
  localparam logic [2:0] A_STATUS = 3'd4;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT} rx_state_t;

  function automatic logic [DW-1:0] data_mask(input logic [1:0] len);
    return 8'hFF >> (2'd3 - len);
  endfunction

  // Bus decode: one access per stb, side effects in the sampled cycle
  logic req, wr, rd;
  assign req = wb_stb & ~wb_ack;
  assign wr  = req & wb_we;
  assign rd  = req & ~wb_we;

  logic [DW-1:0] div_q;
  logic [6:0]    ctrl_q;
  logic [DW-1:0] tick_cnt;
  logic          tick;
  logic          ovr_q, ferr_q, perr_q;

  logic [DW-1:0] tx_dout, rx_dout;
  logic          tx_empty, tx_full, rx_empty, rx_full;
  logic          tx_idle_c;
  logic [DW-1:0] status_c;
  logic [DW-1:0] rd_data_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= 8'(DIV_RESET);
      ctrl_q <= 7'h03;
    end else if (wr) begin
      if (wb_addr == A_DIV)  div_q  <= wb_dat_i;
      if (wb_addr == A_CTRL) ctrl_q <= wb_dat_i[6:0];
    end
  end

  // Oversample tick: counter 0..DIV, restarted by a DIV write
  assign tick = (tick_cnt == div_q);

  always_ff @(posedge clk) begin
    if (reset)                        tick_cnt <= '0;
    else if (wr && wb_addr == A_DIV)  tick_cnt <= '0;
    else if (tick)                    tick_cnt <= '0;
    else                              tick_cnt <= tick_cnt + DW'(1);
  end

  // ---------------- TX path ----------------
  tx_state_t     tx_state, tx_state_n;
  logic [4:0]    tx_tcnt;
  logic [2:0]    tx_bit;
  logic [DW-1:0] tx_data;
  logic [4:0]    tx_cfg;
  logic          tx_load_c;
  logic          tx_c;
  logic          tx_par_c;
  logic          tx_bit_end, tx_stop_end, tx_last_bit;

  assign tx_bit_end  = tick && (tx_tcnt == 5'd15);
  assign tx_stop_end = tick && (tx_tcnt == (tx_cfg[4] ? 5'd31 : 5'd15));
  assign tx_last_bit = (tx_bit == {1'b1, tx_cfg[1:0]});
  assign tx_par_c    = ^(tx_data & data_mask(tx_cfg[1:0])) ^ tx_cfg[3];
  assign tx_idle_c   = tx_empty && (tx_state == TX_IDLE);

  always_ff @(posedge clk) begin
    if (reset) tx_state <= TX_IDLE;
    else       tx_state <= tx_state_n;
  end

  // STOP chains straight into START when more data is queued
  always_comb begin
    tx_state_n = tx_state;
    tx_load_c  = 1'b0;
    case (tx_state)
      TX_IDLE: if (!tx_empty) begin
        tx_state_n = TX_START;
        tx_load_c  = 1'b1;
      end
      TX_START: if (tx_bit_end) tx_state_n = TX_DATA;
      TX_DATA:  if (tx_bit_end && tx_last_bit) tx_state_n = tx_cfg[2] ? TX_PAR : TX_STOP;
      TX_PAR:   if (tx_bit_end) tx_state_n = TX_STOP;
      TX_STOP:  if (tx_stop_end) begin
        if (!tx_empty) begin
          tx_state_n = TX_START;
          tx_load_c  = 1'b1;
        end else begin
          tx_state_n = TX_IDLE;
        end
      end
      default:  tx_state_n = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_c = 1'b1;
    case (tx_state)
      TX_START: tx_c = 1'b0;
      TX_DATA:  tx_c = tx_data[tx_bit];
      TX_PAR:   tx_c = tx_par_c;
      default:  tx_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx      <= 1'b1;
      tx_tcnt <= '0;
      tx_bit  <= '0;
      tx_data <= '0;
      tx_cfg  <= '0;
    end else begin
      tx <= tx_c;
      if (tx_load_c) begin
        tx_data <= tx_dout;
        tx_cfg  <= ctrl_q[4:0];
        tx_tcnt <= '0;
        tx_bit  <= '0;
      end else if (tick && tx_state != TX_IDLE) begin
        if (tx_bit_end && tx_state != TX_STOP) begin
          tx_tcnt <= '0;
          if (tx_state == TX_DATA) tx_bit <= tx_bit + 3'd1;
        end else begin
          tx_tcnt <= tx_tcnt + 5'd1;
        end
      end
    end
  end

  uart_cfg_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (wr && wb_addr == A_TXDATA),
    .pop     (tx_load_c),
    .din     (wb_dat_i),
    .dout_c  (tx_dout),
    .empty_c (tx_empty),
    .full_c  (tx_full)
  );

  // ---------------- RX path ----------------
  rx_state_t     rx_state, rx_state_n;
  logic          rx_meta, rx_sync, rx_prev;
  logic [3:0]    rx_tcnt;
  logic [2:0]    rx_bit;
  logic [DW-1:0] rx_shift;
  logic [3:0]    rx_cfg;
  logic          rx_perr_pend;
  logic          rx_start_c, rx_sample_c, rx_last_bit;
  logic          rx_push_c, rx_ferr_c;
  logic [DW-1:0] rx_byte_c;

  always_ff @(posedge clk) begin
    if (reset) {rx_meta, rx_sync, rx_prev} <= 3'b111;
    else       {rx_meta, rx_sync, rx_prev} <= {rx, rx_meta, rx_sync};
  end

  assign rx_start_c  = (rx_state == RX_IDLE) && rx_prev && !rx_sync;
  assign rx_sample_c = tick && (rx_state == RX_START ? rx_tcnt == 4'd7 : rx_tcnt == 4'd15);
  assign rx_last_bit = (rx_bit == {1'b1, rx_cfg[1:0]});
  // Bits enter at the MSB; right-align to the configured width
  assign rx_byte_c   = rx_shift >> (2'd3 - rx_cfg[1:0]);

  always_ff @(posedge clk) begin
    if (reset) rx_state <= RX_IDLE;
    else       rx_state <= rx_state_n;
  end

  always_comb begin
    rx_state_n = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_start_c) rx_state_n = RX_START;
      RX_START: if (rx_sample_c) rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_sample_c && rx_last_bit) rx_state_n = rx_cfg[2] ? RX_PAR : RX_STOP;
      RX_PAR:   if (rx_sample_c) rx_state_n = RX_STOP;
      RX_STOP:  if (rx_sample_c) rx_state_n = rx_sync ? RX_IDLE : RX_WAIT;
      RX_WAIT:  if (rx_sync) rx_state_n = RX_IDLE;
      default:  rx_state_n = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_push_c = 1'b0;
    rx_ferr_c = 1'b0;
    if (rx_state == RX_STOP && rx_sample_c) begin
      rx_push_c = rx_sync;
      rx_ferr_c = !rx_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_tcnt      <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_cfg       <= '0;
      rx_perr_pend <= 1'b0;
    end else if (rx_start_c) begin
      rx_cfg       <= ctrl_q[3:0];
      rx_tcnt      <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_perr_pend <= 1'b0;
    end else if (tick && rx_state != RX_IDLE && rx_state != RX_WAIT) begin
      if (rx_sample_c) begin
        rx_tcnt <= '0;
        if (rx_state == RX_DATA) begin
          rx_shift <= {rx_sync, rx_shift[DW-1:1]};
          rx_bit   <= rx_bit + 3'd1;
        end
        if (rx_state == RX_PAR) rx_perr_pend <= rx_sync ^ ^rx_byte_c ^ rx_cfg[3];
      end else begin
        rx_tcnt <= rx_tcnt + 4'd1;
      end
    end
  end

  uart_cfg_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (rx_push_c),
    .pop     (rd && wb_addr == A_RXDATA),
    .din     (rx_byte_c),
    .dout_c  (rx_dout),
    .empty_c (rx_empty),
    .full_c  (rx_full)
  );

  // Sticky error flags; a set in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      if (wr && wb_addr == A_STATUS) begin
        if (wb_dat_i[3]) ovr_q  <= 1'b0;
        if (wb_dat_i[4]) ferr_q <= 1'b0;
        if (wb_dat_i[5]) perr_q <= 1'b0;
      end
      if (rx_push_c && rx_full)                    ovr_q  <= 1'b1;
      if (rx_ferr_c)                               ferr_q <= 1'b1;
      if (rx_push_c && rx_cfg[2] && rx_perr_pend)  perr_q <= 1'b1;
    end
  end

  assign status_c = {2'b00, perr_q, ferr_q, ovr_q, tx_idle_c, tx_full, ~rx_empty};

  always_comb begin
    rd_data_c = '0;
    case (wb_addr)
      A_RXDATA: rd_data_c = rx_empty ? '0 : rx_dout;
      A_DIV:    rd_data_c = div_q;
      A_CTRL:   rd_data_c = {1'b0, ctrl_q};
      A_STATUS: rd_data_c = status_c;
      default:  rd_data_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_ack   <= 1'b0;
      wb_dat_o <= '0;
      irq      <= 1'b0;
    end else begin
      wb_ack   <= req;
      wb_dat_o <= rd ? rd_data_c : '0;
      irq      <= (ctrl_q[5] & ~rx_empty) | (ctrl_q[6] & tx_idle_c) |
                  (ctrl_q[5] & (ovr_q | ferr_q | perr_q));
    end
  end
endmodule

// File: tb/tb_uart_cfg.sv
// Bench for uart_cfg: randomized loopback frames checked against a frame-level
// model, plus directed overrun, framing/parity error, handshake and reset cases.

module tb_uart_cfg;
  localparam int unsigned RX_DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx, rx, rx_drv, loop_en;
  logic [2:0] wb_addr;
  logic [7:0] wb_dat_i, wb_dat_o;
  logic       wb_we, wb_stb, wb_ack, irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign rx = loop_en ? tx : rx_drv;

  uart_cfg #(.TX_DEPTH(16), .RX_DEPTH(RX_DEPTH), .DIV_RESET(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .tx       (tx),
    .rx       (rx),
    .wb_addr  (wb_addr),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_we    (wb_we),
    .wb_stb   (wb_stb),
    .wb_ack   (wb_ack),
    .irq      (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    wb_addr = a; wb_dat_i = d; wb_we = 1'b1; wb_stb = 1'b1;
    @(negedge clk);
    wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wb_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    wb_addr = a; wb_we = 1'b0; wb_stb = 1'b1;
    @(negedge clk);
    d = wb_dat_o; wb_stb = 1'b0;
  endtask

  function automatic logic [7:0] data_mask(input logic [7:0] ctrl);
    int n;
    n = 5 + int'(ctrl[1:0]);
    return 8'((1 << n) - 1);
  endfunction

  // Captures one transmitted frame and compares it with the bit list the frame rules give
  task automatic check_tx_frame(input logic [7:0] ctrl, input logic [7:0] div,
                                input logic [7:0] data, input string tag);
    logic exp_bits[$];
    logic wave[$];
    int   n, bitlen, ones, bad;
    bit   found;
    n = 5 + int'(ctrl[1:0]);
    bitlen = 16 * (int'(div) + 1);
    ones = 0; bad = 0; found = 0;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      exp_bits.push_back(data[i]);
      ones += int'(data[i]);
    end
    if (ctrl[2]) exp_bits.push_back(((ones % 2) == 1) ^ ctrl[3]);
    exp_bits.push_back(1'b1);
    if (ctrl[4]) exp_bits.push_back(1'b1);
    for (int c = 0; c < 4000 && !found; c++) begin
      @(negedge clk);
      if (tx === 1'b0) found = 1;
    end
    check({tag, "_start_seen"}, 32'(found), 1);
    if (!found) return;
    wave.push_back(tx);
    for (int c = 1; c < exp_bits.size() * bitlen; c++) begin
      @(negedge clk);
      wave.push_back(tx);
    end
    for (int i = 0; i < exp_bits.size(); i++)
      check($sformatf("%s_bit%0d", tag, i), 32'(wave[i * bitlen + bitlen / 2]), 32'(exp_bits[i]));
    if (div == 8'd0) begin
      for (int c = 0; c < wave.size(); c++)
        if (wave[c] !== exp_bits[c / 16]) bad++;
      check({tag, "_exact_wave"}, 32'(bad), 0);
    end
  endtask

  task automatic wait_tx_idle(input string tag);
    logic [7:0] s;
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      wb_read(3'd4, s);
      if (s[2]) ok = 1;
    end
    check({tag, "_idle"}, 32'(ok), 1);
  endtask

  task automatic run_loop_frame(input logic [7:0] div, input logic [7:0] ctrl,
                                input logic [7:0] data, input string tag);
    logic [7:0] d;
    loop_en = 1'b1;
    wb_write(3'd2, div);
    wb_write(3'd3, ctrl);
    wb_write(3'd0, data);
    check_tx_frame(ctrl, div, data, tag);
    wait_tx_idle(tag);
    wb_read(3'd4, d);
    check({tag, "_status"}, 32'(d), 32'h05);
    wb_read(3'd1, d);
    check({tag, "_rxdata"}, 32'(d), 32'(data & data_mask(ctrl)));
  endtask

  // Drives a serial frame on rx at DIV=0 (16 clk per bit); leaves rx at the stop level
  task automatic drive_frame(input logic [7:0] d, input int n, input bit par_en,
                             input logic par, input logic stop);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      rx_drv = d[i];
      repeat (16) @(negedge clk);
    end
    if (par_en) begin
      rx_drv = par;
      repeat (16) @(negedge clk);
    end
    rx_drv = stop;
    repeat (16) @(negedge clk);
  endtask

  initial begin
    logic [7:0] d, b;
    logic [3:0] acks;
    logic [7:0] exp_q[$];
    int ones;

    wb_stb = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_dat_i = '0;
    rx_drv = 1'b1; loop_en = 1'b0; reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 1);
    check("rst_ack", 32'(wb_ack), 0);
    check("rst_dat_o", 32'(wb_dat_o), 0);
    check("rst_irq", 32'(irq), 0);
    reset = 1'b0;

    wb_read(3'd4, d); check("rst_status", 32'(d), 32'h04);
    wb_read(3'd2, d); check("rst_div", 32'(d), 6);
    wb_read(3'd3, d); check("rst_ctrl", 32'(d), 32'h03);
    wb_read(3'd1, d); check("rx_empty_read", 32'(d), 0);
    wb_read(3'd0, d); check("txdata_read", 32'(d), 0);
    wb_read(3'd6, d); check("unmapped_read", 32'(d), 0);
    wb_write(3'd3, 8'h83);
    wb_read(3'd3, d); check("ctrl_bit7", 32'(d), 32'h03);

    // stb held high: one access every two cycles
    @(negedge clk);
    wb_addr = 3'd2; wb_we = 1'b0; wb_stb = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      @(negedge clk);
      acks[i] = wb_ack;
    end
    wb_stb = 1'b0;
    check("ack_pattern", 32'(acks), 32'b1010);

    run_loop_frame(8'd0, 8'h03, 8'h55, "t1_8n1");
    run_loop_frame(8'd0, 8'h0F, 8'hA7, "t2_8o1");
    run_loop_frame(8'd0, 8'h10, 8'hFF, "t3_5n2");
    for (int i = 0; i < 8; i++)
      run_loop_frame(8'($urandom_range(0, 2)), 8'($urandom_range(0, 31)), 8'($urandom),
                     $sformatf("rnd%0d", i));

    // Overrun: RX_DEPTH+1 frames with no reads
    loop_en = 1'b1;
    wb_write(3'd2, 8'd0);
    wb_write(3'd3, 8'h23);
    for (int i = 0; i < RX_DEPTH + 1; i++) begin
      b = 8'($urandom);
      if (exp_q.size() < RX_DEPTH) exp_q.push_back(b);
      if (i == 8) wait_tx_idle("ovr_mid");
      wb_write(3'd0, b);
    end
    wait_tx_idle("ovr_end");
    repeat (40) @(negedge clk);
    wb_read(3'd4, d); check("ovr_status", 32'(d), 32'h0D);
    check("ovr_irq", 32'(irq), 1);
    for (int i = 0; i < RX_DEPTH; i++) begin
      wb_read(3'd1, d);
      check($sformatf("ovr_rx%0d", i), 32'(d), 32'(exp_q[i]));
    end
    wb_read(3'd1, d); check("ovr_drained", 32'(d), 0);
    wb_read(3'd4, d); check("ovr_sticky", 32'(d), 32'h0C);
    check("ovr_irq_err", 32'(irq), 1);
    wb_write(3'd4, 8'h08);
    wb_read(3'd4, d); check("ovr_clear", 32'(d), 32'h04);
    check("irq_cleared", 32'(irq), 0);
    wb_write(3'd3, 8'h43);
    repeat (2) @(negedge clk);
    check("irq_tx_empty", 32'(irq), 1);

    // Framing error: stop bit low
    loop_en = 1'b0;
    wb_write(3'd3, 8'h03);
    drive_frame(8'($urandom), 8, 1'b0, 1'b0, 1'b0);
    repeat (16) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    wb_read(3'd4, d); check("ferr_status", 32'(d), 32'h14);
    wb_write(3'd4, 8'h10);
    wb_read(3'd4, d); check("ferr_clear", 32'(d), 32'h04);

    // Parity error: byte still delivered
    wb_write(3'd3, 8'h07);
    b = 8'($urandom);
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    drive_frame(b, 8, 1'b1, ~((ones % 2) == 1), 1'b1);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    wb_read(3'd4, d); check("perr_status", 32'(d), 32'h25);
    wb_read(3'd1, d); check("perr_data", 32'(d), 32'(b));
    wb_write(3'd4, 8'h20);
    wb_read(3'd4, d); check("perr_clear", 32'(d), 32'h04);

    // Reset in the middle of a frame's data bits (all-zero data keeps tx low)
    loop_en = 1'b1;
    wb_write(3'd2, 8'd0);
    wb_write(3'd3, 8'h03);
    wb_write(3'd0, 8'h00);
    repeat (40) @(negedge clk);
    check("pre_reset_tx_low", 32'(tx), 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_reset_tx", 32'(tx), 1);
    wb_read(3'd4, d); check("mid_reset_status", 32'(d), 32'h04);
    wb_read(3'd2, d); check("mid_reset_div", 32'(d), 6);
    loop_en = 1'b0;
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (300) @(negedge clk);
    wb_read(3'd4, d); check("glitch_status", 32'(d), 32'h04);
    check("glitch_tx_idle", 32'(tx), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
